serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
Bit-serial addition controller that sequences one external `fulladder` instance over WIDTH-bit operands, least-significant bit first, one bit per clock. It captures the operands on a start request and steps the shared full adder through all bits while holding the running carry in a register. It then presents the registered sum and carry-out with a one-cycle done pulse. It sits between a requester and the single `fulladder` datapath cell, trading area for latency.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1 to 32.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous and active-low.
start  input  1  request to begin an addition; sampled only in IDLE.
a  input  WIDTH  operand A; captured on accepted start.
b  input  WIDTH  operand B; captured on accepted start.
cin  input  1  carry-in; captured on accepted start.
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle pulse; s and cout are valid from this cycle onward.
s  output  WIDTH  registered sum; holds its value until the next completion.
cout  output  1  registered carry-out; holds its value until the next completion.
fa_a  output  1  drives the `a` input of the external full adder.
fa_b  output  1  drives the `b` input of the external full adder.
fa_cin  output  1  drives the `cin` input of the external full adder.
fa_s  input  1  `s` output of the external full adder (combinational).
fa_cout  input  1  `cout` output of the external full adder (combinational).

Behaviour:
- One clock; reset is synchronous and active-low.
- When rst_n is low at a rising edge:
  - state goes to IDLE;
  - s, cout, done, busy, carry register, bit counter and both shift registers are cleared to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge loads areg<=a, breg<=b, carry<=cin, sreg<=0, cnt<=0, then goes to RUN.
  - start=0 stays in IDLE.
- RUN:
  - fa_a=areg[0], fa_b=breg[0], fa_cin=carry, all driven combinationally from registers.
  - Each edge:
    - sreg <= {fa_s, sreg[WIDTH-1:1]};
    - carry <= fa_cout;
    - areg and breg shift right by 1;
    - cnt <= cnt+1.
  - At the edge where cnt==WIDTH-1:
    - s <= {fa_s, sreg[WIDTH-1:1]};
    - cout <= fa_cout;
    - go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge returns to IDLE unconditionally.
- fa_a, fa_b and fa_cin are 0 in IDLE and DONE.
- s and cout never show partial results; they change only on the final RUN edge or on reset.
- Latency: start sampled at edge E0 → RUN covers edges E1..E_WIDTH → done high between E_WIDTH and E_WIDTH+1.
- busy is high from E0 through E_WIDTH+1.
- start while busy is ignored; there is no queuing.
- start held high continuously gives one operation every WIDTH+2 cycles. Operands are re-sampled at each acceptance.
- a, b and cin may change freely after acceptance without affecting the operation in flight.
- Reset during RUN or DONE aborts the operation; no done pulse follows.
- WIDTH=1: RUN lasts one cycle and the result equals a single full-adder evaluation.
- cnt width is clog2(WIDTH), minimum 1 bit.
- Arithmetic: {cout,s} = a + b + cin, exact, modulo 2^(WIDTH+1) (never overflows).
- The external full adder must be purely combinational; no pipeline stage is allowed between fa_* outputs and fa_s/fa_cout.

Test Plan:
- WIDTH=8, start with a=0x00, b=0x00, cin=0 → done pulses exactly 9 cycles after the start edge; s=0x00, cout=0; busy falls the cycle after done.
- a=0xFF, b=0x01, cin=0 → s=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 → s=0x00, cout=1. Then a=0x3C, b=0x42, cin=0 → s=0x7E, cout=0.
- Pulse start with a=0x10, b=0x20; drive a=0xFF and pulse start again during RUN → the second start is ignored; result s=0x30, cout=0; exactly one done pulse.
- Assert rst_n=0 for one edge after the 3rd RUN edge → s=0, cout=0, busy=0, no done. A following start with a=0x80, b=0x80, cin=0 → s=0x00, cout=1.
- Hold start=1 for 40 cycles with a=0x01, b=0x01 → done pulses every 10 cycles, 4 pulses total, each with s=0x02; s stable between pulses.
- WIDTH=1: all 8 combinations of a, b, cin → {cout,s} matches the full-adder truth table; done 2 cycles after each start.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: steps one external combinational full adder
// over WIDTH-bit operands, LSB first, and presents the result with a done pulse.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_s,
   input  logic             fa_cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_r;
   logic [WIDTH-1:0] areg_r;
   logic [WIDTH-1:0] breg_r;
   logic [WIDTH-1:0] sreg_r;
   logic [WIDTH-1:0] s_r;
   logic [CW-1:0]    cnt_r;
   logic             carry_r;
   logic             cout_r;
   logic             done_r;
   logic             busy_r;
   logic [WIDTH-1:0] sreg_next_s;
   logic             fa_a_s;
   logic             fa_b_s;
   logic             fa_cin_s;

   // New sum bit enters at the MSB so that after WIDTH steps bit 0 sits at the LSB.
   generate
      if (WIDTH == 1) begin : g_w1
         assign sreg_next_s = fa_s;
      end else begin : g_wn
         assign sreg_next_s = {fa_s, sreg_r[WIDTH-1:1]};
      end
   endgenerate

   // Full-adder operands come straight from registers; quiet outside RUN.
   always_comb begin
      fa_a_s   = 1'b0;
      fa_b_s   = 1'b0;
      fa_cin_s = 1'b0;
      if (state_r == RUN) begin
         fa_a_s   = areg_r[0];
         fa_b_s   = breg_r[0];
         fa_cin_s = carry_r;
      end else begin
         fa_a_s   = 1'b0;
         fa_b_s   = 1'b0;
         fa_cin_s = 1'b0;
      end
   end

   // Sequencer: capture on start, one bit per edge, publish on the last bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         areg_r  <= '0;
         breg_r  <= '0;
         sreg_r  <= '0;
         s_r     <= '0;
         cnt_r   <= '0;
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  areg_r  <= a;
                  breg_r  <= b;
                  carry_r <= cin;
                  sreg_r  <= '0;
                  cnt_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            RUN: begin
               sreg_r  <= sreg_next_s;
               carry_r <= fa_cout;
               areg_r  <= areg_r >> 1;
               breg_r  <= breg_r >> 1;
               cnt_r   <= cnt_r + 1'b1;
               if (cnt_r == LAST_CNT) begin
                  s_r     <= sreg_next_s;
                  cout_r  <= fa_cout;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else begin
                  done_r  <= 1'b0;
                  state_r <= RUN;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign s      = s_r;
   assign cout   = cout_r;
   assign fa_a   = fa_a_s;
   assign fa_b   = fa_b_s;
   assign fa_cin = fa_cin_s;

endmodule
